// File: rtl/sdm_dac_ideal.sv
// First-order sigma-delta DAC: each accepted WIDTH-bit code becomes an OSR-bit frame whose ones-density is code/2^WIDTH.
// First bit one cycle after accept; one-entry pending buffer while running. Define SDM_DAC_FORMAL_EN for sby properties.
module sdm_dac_ideal #(
    parameter int WIDTH = 10,
    parameter int OSR   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] code_digital,
    input  logic             code_valid,
    output logic             code_ready,
    output logic             dac_bit_out,
    output logic [WIDTH-1:0] output_voltage_real,
    output logic             frame_done,
    output logic             busy
);
    localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] volt_q, volt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_vld_q, pend_vld_d;
    logic             bit_q, bit_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   sum;
    logic             accept;
    logic             last;

    always_comb begin
        code_ready = !reset && ((state_q == IDLE) || !pend_vld_q);
        accept     = code_valid && code_ready;
        sum        = {1'b0, acc_q} + {1'b0, cur_q};
        last       = (cnt_q == CW'(OSR - 1));

        state_d    = state_q;
        acc_d      = acc_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        volt_d     = volt_q;
        cnt_d      = cnt_q;
        bit_d      = 1'b0;
        done_d     = 1'b0;

        if (state_q == IDLE) begin
            if (accept) begin
                state_d = RUN;
                cur_d   = code_digital;
                volt_d  = code_digital;
                acc_d   = '0;
                cnt_d   = '0;
            end
        end else begin
            // The carry out of the accumulator is the modulator bit.
            acc_d = sum[WIDTH-1:0];
            bit_d = sum[WIDTH];
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                done_d = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
                // Reload on the last-bit edge so the next frame follows without a gap.
                if (pend_vld_q) begin
                    cur_d      = pend_q;
                    volt_d     = pend_q;
                    pend_vld_d = 1'b0;
                end else if (accept) begin
                    cur_d  = code_digital;
                    volt_d = code_digital;
                end else begin
                    state_d = IDLE;
                end
            end else if (accept) begin
                pend_d     = code_digital;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cur_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            volt_q     <= '0;
            cnt_q      <= '0;
            bit_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            volt_q     <= volt_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            done_q     <= done_d;
        end
    end

    assign dac_bit_out         = bit_q;
    assign output_voltage_real = volt_q;
    assign frame_done          = done_q;
    assign busy                = (state_q == RUN);

`ifdef SDM_DAC_FORMAL_EN
    localparam int PW = WIDTH + CW + 1;

    logic [CW:0]      fv_ones_q;
    logic [WIDTH-1:0] fv_code_q;
    logic [PW-1:0]    fv_expect;

    // Ones emitted so far in the frame, and the code that frame is converting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fv_ones_q <= '0;
            fv_code_q <= '0;
        end else if (state_q == RUN) begin
            fv_ones_q <= (cnt_q == '0) ? (CW+1)'(sum[WIDTH]) : fv_ones_q + (CW+1)'(sum[WIDTH]);
            fv_code_q <= cur_q;
        end
    end

    assign fv_expect = (PW'(OSR) * PW'(fv_code_q)) >> WIDTH;

    a_idle_quiet: assert property (@(posedge clk) disable iff (reset)
        (state_q == IDLE && !frame_done) |-> (!dac_bit_out && !busy));
    a_done_wrap: assert property (@(posedge clk) disable iff (reset)
        frame_done |-> (cnt_q == '0));
    a_full_not_ready: assert property (@(posedge clk) disable iff (reset)
        pend_vld_q |-> !code_ready);
    a_ones_count: assert property (@(posedge clk) disable iff (reset)
        frame_done |-> (PW'(fv_ones_q) == fv_expect));
    c_back_to_back: cover property (@(posedge clk) disable iff (reset)
        frame_done && busy);
`endif

endmodule

// File: tb/tb_sdm_dac_ideal.sv
// Bench for sdm_dac_ideal: an OSR=16 instance checked bit-by-bit and a default instance checked per-frame ones count.
module tb_sdm_dac_ideal;
    localparam int W     = 10;
    localparam int OSR_A = 16;
    localparam int OSR_B = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] a_code, a_volt, b_code, b_volt;
    logic         a_valid, a_ready, a_bit, a_done, a_busy;
    logic         b_valid, b_ready, b_bit, b_done, b_busy;

    sdm_dac_ideal #(.WIDTH(W), .OSR(OSR_A)) u_dut_a (
        .clk(clk), .reset(reset), .code_digital(a_code), .code_valid(a_valid),
        .code_ready(a_ready), .dac_bit_out(a_bit), .output_voltage_real(a_volt),
        .frame_done(a_done), .busy(a_busy)
    );

    sdm_dac_ideal #(.WIDTH(W), .OSR(OSR_B)) u_dut_b (
        .clk(clk), .reset(reset), .code_digital(b_code), .code_valid(b_valid),
        .code_ready(b_ready), .dac_bit_out(b_bit), .output_voltage_real(b_volt),
        .frame_done(b_done), .busy(b_busy)
    );

    int checks   = 0;
    int failures = 0;
    int exp_a[$];
    int exp_b[$];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Bit i (1-based) of a frame: ones in the first i bits are floor(i*code/2^W).
    function automatic int model_bit(input int c, input int i);
        return ((i * c) / (1 << W)) - (((i - 1) * c) / (1 << W));
    endfunction

    // Monitor A: pops an expected code whenever a frame starts and checks every bit.
    int a_idx       = -1;
    int a_cur       = 0;
    int a_last_volt = 0;
    always @(negedge clk) begin
        if (reset) begin
            a_idx       = -1;
            a_last_volt = 0;
        end else begin
            if (a_idx >= 0) begin
                a_idx++;
                check("a_bit", a_bit, model_bit(a_cur, a_idx));
                check("a_frame_done", a_done, a_idx == OSR_A);
                if (a_idx < OSR_A) check("a_busy_in_frame", a_busy, 1);
                if (a_idx == OSR_A) a_idx = -1;
            end else begin
                check("a_idle_bit", a_bit, 0);
                check("a_idle_done", a_done, 0);
                if (!a_busy) check("a_idle_volt_held", a_volt, a_last_volt);
            end
            if (a_idx < 0 && a_busy) begin
                if (exp_a.size() == 0) begin
                    check("a_unexpected_frame_queue", exp_a.size(), 1);
                end else begin
                    a_cur       = exp_a.pop_front();
                    a_last_volt = a_cur;
                    check("a_volt_at_start", a_volt, a_cur);
                    a_idx = 0;
                end
            end
        end
    end

    // Monitor B: counts ones produced in RUN and compares at each frame_done.
    int  b_ones      = 0;
    logic b_prev_busy = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            b_ones      = 0;
            b_prev_busy = 1'b0;
        end else begin
            if (b_prev_busy && b_bit) b_ones++;
            if (b_done) begin
                if (exp_b.size() == 0) check("b_unexpected_frame_queue", exp_b.size(), 1);
                else check("b_frame_ones", b_ones, exp_b.pop_front());
                b_ones = 0;
            end
            b_prev_busy = b_busy;
        end
    end

    task automatic send_a(input int c);
        int n = 0;
        a_code  = W'(c);
        a_valid = 1'b1;
        while (!a_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("a_ready_for_accept", a_ready, 1);
        if (a_ready) exp_a.push_back(c);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic send_b(input int c, input int expected_ones);
        int n = 0;
        b_code  = W'(c);
        b_valid = 1'b1;
        while (!b_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("b_ready_for_accept", b_ready, 1);
        if (b_ready) exp_b.push_back(expected_ones);
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while ((a_busy || exp_a.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("a_drain_busy", a_busy, 0);
        check("a_drain_queue", exp_a.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_idle_b();
        int n = 0;
        while ((b_busy || exp_b.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("b_drain_busy", b_busy, 0);
        check("b_drain_queue", exp_b.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        a_valid = 1'b0; a_code = '0;
        b_valid = 1'b0; b_code = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_a_bit", a_bit, 0);
        check("rst_a_volt", a_volt, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("post_rst_a_ready", a_ready, 1);

        // Half-scale: alternating bits, then back to idle.
        send_a(512);
        wait_idle_a();

        // Second code held in pending while the first frame runs.
        send_a(256);
        send_a(768);
        repeat (10) begin
            @(negedge clk);
            check("a_ready_pending_full", a_ready, 0);
        end
        wait_idle_a();

        // Code arrives exactly on the frame_done edge with pending empty.
        send_a(100);
        repeat (15) @(negedge clk);
        send_a(12'h166);
        check("a_ready_after_bypass", a_ready, 1);
        wait_idle_a();

        // Full-scale extremes.
        send_a(0);
        send_a(1023);
        wait_idle_a();

        // Continuous valid: every accepted code gets exactly one frame.
        for (int i = 0; i < 8; i++) send_a($urandom_range(0, 1023));
        wait_idle_a();

        // Random codes with random gaps.
        for (int i = 0; i < 25; i++) begin
            send_a($urandom_range(0, 1023));
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_idle_a();

        // Reset mid-frame with pending full: everything in flight is dropped.
        send_a(300);
        send_a(700);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        exp_a.delete();
        #1;
        check("midrst_a_bit", a_bit, 0);
        check("midrst_a_volt", a_volt, 0);
        check("midrst_a_done", a_done, 0);
        check("midrst_a_busy", a_busy, 0);
        check("midrst_a_ready", a_ready, 0);
        @(negedge clk);
        check("midrst_a_ready_held", a_ready, 0);
        #2 reset = 1'b0;
        @(negedge clk);
        check("after_rst_a_ready", a_ready, 1);
        check("after_rst_a_busy", a_busy, 0);
        repeat (30) @(negedge clk);
        check("after_rst_pending_dropped", a_busy, 0);

        // Default geometry: ones count equals the code when OSR = 2^W.
        send_b(12'h28A, (OSR_B * 650) / (1 << W));
        wait_idle_b();
        send_b(0, 0);
        send_b(1023, (OSR_B * 1023) / (1 << W));
        wait_idle_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdm_dac_ideal.md
Name: sdm_dac_ideal

Overview:
- First-order sigma-delta DAC: the output-direction counterpart to the SAR ADC path.
- Accepts WIDTH-bit digital codes over a valid/ready handshake.
- For each code, emits a frame of OSR single-bit samples whose ones-density equals code/2^WIDTH.
- Also holds an ideal "real" copy of the current code so the test harness can loop DAC into ADC.

Parameters:
- WIDTH, 10, code width; must match the ADC voltage bus width.
- OSR, 1024, bitstream cycles per code (frame length). Power of two, 2 <= OSR <= 2^WIDTH.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- code_digital  input  WIDTH  code to convert.
- code_valid  input  1  code_digital is valid this cycle.
- code_ready  output  1  block can accept a code this cycle.
- dac_bit_out  output  1  registered modulator bitstream.
- output_voltage_real  output  WIDTH  ideal held value of the code in the current frame.
- frame_done  output  1  one-cycle pulse, registered with the last bit of each frame.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE; acc=0; cnt=0; cur_code=0; pending empty.
  - dac_bit_out=0, output_voltage_real=0, frame_done=0, busy=0.
  - code_ready=0 while reset is asserted.
- States: IDLE, RUN.
- Acceptance: accept = code_valid & code_ready.
  - code_ready = !reset & (state==IDLE | pending empty).
  - This gives one-entry buffering while RUN.
- IDLE, accept at edge k:
  - state->RUN; cur_code=code_digital; acc=0; cnt=0.
  - output_voltage_real=code_digital at edge k.
  - busy=1 after edge k.
- RUN, each edge:
  - {carry,acc} <= acc + cur_code, computed at WIDTH+1 bits; acc keeps the low WIDTH bits.
  - dac_bit_out <= carry; cnt <= cnt+1.
  - First bit is visible after edge k+1; OSR bits total per frame.
- Frame content: ones count in a frame = floor(OSR*code/2^WIDTH), exactly (acc starts at 0 every frame).
  - code=0 gives an all-zero frame.
  - code=2^WIDTH-1 with OSR=2^WIDTH gives OSR-1 ones.
- Frame end (edge where cnt==OSR-1): frame_done=1 for that cycle, then:
  - If pending full: start a new frame next edge (cur_code=pending, acc=0, cnt=0, output_voltage_real=pending, pending cleared). No idle gap in the bitstream.
  - Else if accept on that same edge: bypass directly into the new frame as above.
  - Else: state->IDLE; dac_bit_out<=0 on the next edge; busy=0; output_voltage_real keeps its last value.
- RUN with pending empty: accept stores the code in pending; code_ready drops the next cycle.
- Pending full: code_ready=0; code_valid is ignored and must be held by the source.
- cnt is log2(OSR) bits wide and wraps to 0 at frame end.
- Mid-frame reset: bits in flight are lost, and the pending code is discarded.

Optional Feature:
- Macro: SDM_DAC_FORMAL_EN.
- With the macro defined, the block embeds the following assertions and covers for sby:
  - dac_bit_out==0 and busy==0 in IDLE;
  - frame_done only when cnt wraps;
  - code_ready==0 whenever pending is full;
  - per-frame ones count equals floor(OSR*cur_code/2^WIDTH) at frame_done;
  - cover of back-to-back frames with no gap.
- Without the macro, there is no formal logic and functional behaviour is identical.

Test Plan:
- OSR=16, single accept of code 512 -> output_voltage_real=512 the same edge; bits 0,1,0,1... (8 ones over 16); frame_done on bit 16; then IDLE, dac_bit_out=0.
- Defaults, code 0x28A (650) -> exactly 650 ones in 1024 bits; code 0 -> 0 ones; code 1023 -> 1023 ones.
- OSR=16, accept 256, then accept 768 during RUN -> code_ready low until the frame ends; second frame starts the next edge with no gap; 4 ones then 12 ones; two frame_done pulses 16 cycles apart.
- OSR=16, code_valid held high with new codes continuously -> every accept gets its own frame and no code is dropped or duplicated.
- Assert reset at bit 7 of a frame with pending full -> all outputs 0 immediately; code_ready=0 during reset; after release, IDLE with code_ready=1 and the pending code discarded.
- Code 0x166 accepted exactly on a frame_done cycle with pending empty -> bypass into the next frame; output_voltage_real=0x166 on that edge.
